fsm_ctrl: RTL and testbench
===========================

FSM_CTRL -- requirements
Module: fsm_ctrl

Interface
REQ-001 Parameter THRESH_W, default 3; width of the almost-full and almost-empty threshold fields.
REQ-002 Parameter NUM_FIFOS, default 8; number of monitored FIFOs (4 input, 4 output).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  request to enter or remain in configuration.
REQ-006 umbral_af_in  input  THRESH_W  almost-full threshold to program.
REQ-007 umbral_ae_in  input  THRESH_W  almost-empty threshold to program.
REQ-008 fifo_empty  input  NUM_FIFOS  per-FIFO empty flags; bit i = FIFO i.
REQ-009 fifo_error  input  NUM_FIFOS  per-FIFO overflow/underflow flags.
REQ-010 umbral_af_out  output  THRESH_W  registered almost-full threshold broadcast to all FIFOs.
REQ-011 umbral_ae_out  output  THRESH_W  registered almost-empty threshold broadcast to all FIFOs.
REQ-012 state  output  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
REQ-013 idle_out  output  1  high while state is IDLE.
REQ-014 error_out  output  1  high while state is ERROR.
REQ-015 error_src  output  NUM_FIFOS  latched fifo_error bits that caused ERROR entry.
REQ-016 cfg_invalid  output  1  high while in INIT with an invalid threshold pair.

Function
REQ-017 All outputs SHALL be registered; there SHALL be no combinational path from an input to an output.
REQ-018 The block SHALL implement one-hot states RESET, INIT, IDLE, ACTIVE and ERROR, with state equal to the current-state register.
REQ-019 RESET with reset=0 SHALL go to INIT on the next edge unconditionally.
REQ-020 While in INIT, umbral_af_out and umbral_ae_out SHALL load umbral_af_in and umbral_ae_in on every edge; outside INIT they SHALL hold.
REQ-021 A threshold pair SHALL be valid iff umbral_af_in != 0 and umbral_ae_in < umbral_af_in (unsigned).
REQ-022 INIT SHALL stay in INIT while init=1 or the pair is invalid, and SHALL go to IDLE when init=0 and the pair is valid.
REQ-023 cfg_invalid SHALL register (next state is INIT) and (pair invalid); otherwise it SHALL be 0.
REQ-024 In INIT, fifo_error SHALL be ignored.
REQ-025 IDLE and ACTIVE SHALL evaluate transitions in priority order: any fifo_error bit -> ERROR; else init=1 -> INIT; else the empty-flag rule.
REQ-026 Empty-flag rule: IDLE SHALL go to ACTIVE if any fifo_empty bit is 0; ACTIVE SHALL go to IDLE if all fifo_empty bits are 1; otherwise the state SHALL hold.
REQ-027 On the edge entering ERROR, error_src SHALL load fifo_error; it SHALL hold while in ERROR and clear on reset.
REQ-028 ERROR SHALL be absorbing: init, fifo_empty and fifo_error SHALL be ignored; only reset exits.
REQ-029 idle_out and error_out SHALL be registered copies of (next state is IDLE) and (next state is ERROR), so they align with state.
REQ-030 Latency: every input-driven transition SHALL appear on state exactly one cycle after the sampling edge.

Reset
REQ-031 On any edge with reset=1, regardless of current state: state=00001, umbral_af_out=0, umbral_ae_out=0, idle_out=0, error_out=0, error_src=0, cfg_invalid=0.
REQ-032 Reset asserted mid-operation, including in ERROR, SHALL take priority over every transition and discard the held thresholds.
REQ-033 After reset deasserts, the first edge SHALL give INIT; thresholds SHALL be reprogrammed before IDLE is reachable.

Verification
REQ-034 Reset 2 cycles, then init=1, af_in=6, ae_in=2 for 3 cycles, then init=0 with all fifo_empty=1 -> states RESET, INIT x3, then IDLE; umbral_af_out=6, umbral_ae_out=2; idle_out=1.
REQ-035 In INIT, init=0, af_in=3, ae_in=3 -> stays INIT with cfg_invalid=1; change ae_in to 1 -> IDLE next cycle, cfg_invalid=0.
REQ-036 In IDLE, fifo_empty=8'hFE -> ACTIVE next cycle with idle_out=0; fifo_empty=8'hFF -> IDLE next cycle with idle_out=1.
REQ-037 In ACTIVE, fifo_error=8'h20 and init=1 on the same cycle -> ERROR (error wins); error_out=1, error_src=8'h20; later init/empty/error activity -> remains ERROR, error_src unchanged.
REQ-038 In ERROR, reset=1 for 1 cycle -> all outputs at reset values and state=00001; next cycle state=INIT.
REQ-039 In ACTIVE, init=1 with no error -> INIT; new af_in/ae_in values -> thresholds update in INIT and hold after returning to IDLE.

Source files
------------

// File: rtl/fsm_ctrl.sv
// fsm_ctrl: configuration/supervision controller for a bank of FIFOs.
//
// Sequences RESET -> INIT (threshold programming) -> IDLE/ACTIVE (normal
// operation) and locks into ERROR on any FIFO overflow/underflow until reset.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   init           request to enter/remain in configuration
//   umbral_af_in   almost-full threshold to program
//   umbral_ae_in   almost-empty threshold to program
//   fifo_empty     per-FIFO empty flags (bit i = FIFO i)
//   fifo_error     per-FIFO overflow/underflow flags
//   umbral_af_out  registered almost-full threshold broadcast
//   umbral_ae_out  registered almost-empty threshold broadcast
//   state          one-hot current state
//   idle_out       high while in IDLE
//   error_out      high while in ERROR
//   error_src      fifo_error bits captured on ERROR entry
//   cfg_invalid    high while in INIT with an invalid threshold pair
module fsm_ctrl #(
    parameter int unsigned THRESH_W  = 3,
    parameter int unsigned NUM_FIFOS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [THRESH_W-1:0]  umbral_af_in,
    input  logic [THRESH_W-1:0]  umbral_ae_in,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] fifo_error,
    output logic [THRESH_W-1:0]  umbral_af_out,
    output logic [THRESH_W-1:0]  umbral_ae_out,
    output logic [4:0]           state,
    output logic                 idle_out,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] error_src,
    output logic                 cfg_invalid
);

    typedef enum logic [4:0] {
        StReset  = 5'b00001,
        StInit   = 5'b00010,
        StIdle   = 5'b00100,
        StActive = 5'b01000,
        StError  = 5'b10000
    } state_e;

    state_e state_q, state_d;
    logic   pair_valid;
    logic   any_error;
    logic   all_empty;

    assign pair_valid = (umbral_af_in != '0) && (umbral_ae_in < umbral_af_in);
    assign any_error  = |fifo_error;
    assign all_empty  = &fifo_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StInit;
            // fifo_error is deliberately not looked at while configuring
            StInit:  state_d = (init || !pair_valid) ? StInit : StIdle;
            StIdle: begin
                if (any_error)       state_d = StError;
                else if (init)       state_d = StInit;
                else if (!all_empty) state_d = StActive;
                else                 state_d = StIdle;
            end
            StActive: begin
                if (any_error)      state_d = StError;
                else if (init)      state_d = StInit;
                else if (all_empty) state_d = StIdle;
                else                state_d = StActive;
            end
            StError: state_d = StError;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StReset;
            umbral_af_out <= '0;
            umbral_ae_out <= '0;
            idle_out      <= 1'b0;
            error_out     <= 1'b0;
            error_src     <= '0;
            cfg_invalid   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StInit) begin
                umbral_af_out <= umbral_af_in;
                umbral_ae_out <= umbral_ae_in;
            end
            // Capture only on the entering edge so the cause stays frozen
            if (state_d == StError && state_q != StError) begin
                error_src <= fifo_error;
            end
            // Flags decoded from next state so they line up with state
            idle_out    <= (state_d == StIdle);
            error_out   <= (state_d == StError);
            cfg_invalid <= (state_d == StInit) && !pair_valid;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fsm_ctrl.sv
module tb_fsm_ctrl;

    localparam int TW = 3;
    localparam int NF = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init = 1'b0;
    logic [TW-1:0] af_in = '0;
    logic [TW-1:0] ae_in = '0;
    logic [NF-1:0] fifo_empty = '1;
    logic [NF-1:0] fifo_error = '0;
    logic [TW-1:0] af_out;
    logic [TW-1:0] ae_out;
    logic [4:0]    state;
    logic          idle_out;
    logic          error_out;
    logic [NF-1:0] error_src;
    logic          cfg_invalid;

    fsm_ctrl #(.THRESH_W(TW), .NUM_FIFOS(NF)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_af_in (af_in),
        .umbral_ae_in (ae_in),
        .fifo_empty   (fifo_empty),
        .fifo_error   (fifo_error),
        .umbral_af_out(af_out),
        .umbral_ae_out(ae_out),
        .state        (state),
        .idle_out     (idle_out),
        .error_out    (error_out),
        .error_src    (error_src),
        .cfg_invalid  (cfg_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [4:0]    st;
        logic [TW-1:0] af;
        logic [TW-1:0] ae;
        logic          idle;
        logic          err;
        logic [NF-1:0] src;
        logic          cfg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: states named by index 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR
    int            m_st = 0;
    logic [TW-1:0] m_af = '0;
    logic [TW-1:0] m_ae = '0;
    logic [NF-1:0] m_src = '0;
    logic          m_idle = 1'b0;
    logic          m_err = 1'b0;
    logic          m_cfg = 1'b0;

    task automatic model(input logic r, input logic i, input logic [TW-1:0] af,
                         input logic [TW-1:0] ae, input logic [NF-1:0] emp,
                         input logic [NF-1:0] er);
        int  nxt;
        bit  valid;
        if (r) begin
            m_st = 0; m_af = '0; m_ae = '0; m_src = '0;
            m_idle = 0; m_err = 0; m_cfg = 0;
            return;
        end
        valid = (af != 0) && (ae < af);
        nxt = m_st;
        case (m_st)
            0: nxt = 1;
            1: nxt = (i || !valid) ? 1 : 2;
            2, 3: begin
                if (er != 0)               nxt = 4;
                else if (i)                nxt = 1;
                else if (m_st == 2)        nxt = (emp != {NF{1'b1}}) ? 3 : 2;
                else                       nxt = (emp == {NF{1'b1}}) ? 2 : 3;
            end
            default: nxt = 4;
        endcase
        if (m_st == 1) begin
            m_af = af;
            m_ae = ae;
        end
        if (nxt == 4 && m_st != 4) m_src = er;
        m_idle = (nxt == 2);
        m_err  = (nxt == 4);
        m_cfg  = (nxt == 1) && !valid;
        m_st   = nxt;
    endtask

    task automatic step(input string name, input logic r, input logic i,
                        input logic [TW-1:0] af, input logic [TW-1:0] ae,
                        input logic [NF-1:0] emp, input logic [NF-1:0] er);
        exp_t e;
        @(negedge clk);
        reset = r; init = i; af_in = af; ae_in = ae; fifo_empty = emp; fifo_error = er;
        model(r, i, af, ae, emp, er);
        e.name = name;
        e.st   = 5'(1 << m_st);
        e.af   = m_af;
        e.ae   = m_ae;
        e.idle = m_idle;
        e.err  = m_err;
        e.src  = m_src;
        e.cfg  = m_cfg;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge the DUT presents a new output set; compare after it settles
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (state === e.st && af_out === e.af && ae_out === e.ae &&
                idle_out === e.idle && error_out === e.err &&
                error_src === e.src && cfg_invalid === e.cfg) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%b af=%0d ae=%0d idle=%b err=%b src=%h cfg=%b, want st=%b af=%0d ae=%0d idle=%b err=%b src=%h cfg=%b",
                         e.name, state, af_out, ae_out, idle_out, error_out, error_src,
                         cfg_invalid, e.st, e.af, e.ae, e.idle, e.err, e.src, e.cfg);
            end
        end
    end

    initial begin
        logic          r, i;
        logic [TW-1:0] af, ae;
        logic [NF-1:0] emp, er;

        // Bring-up: reset, program 6/2, release to IDLE
        step("reset0", 1, 0, 0, 0, 8'hFF, 8'h00);
        step("reset1", 1, 0, 0, 0, 8'hFF, 8'h00);
        for (int k = 0; k < 3; k++) step("init_prog", 0, 1, 6, 2, 8'hFF, 8'h00);
        step("to_idle", 0, 0, 6, 2, 8'hFF, 8'h00);

        // Invalid pair holds INIT, fixing ae releases it
        step("reinit", 0, 1, 6, 2, 8'hFF, 8'h00);
        step("cfg_bad_eq", 0, 0, 3, 3, 8'hFF, 8'h00);
        step("cfg_bad_eq2", 0, 0, 3, 3, 8'hFF, 8'h00);
        step("cfg_bad_zero", 0, 0, 0, 0, 8'hFF, 8'h00);
        step("cfg_fix", 0, 0, 3, 1, 8'hFF, 8'h00);

        // Empty-flag rule
        step("idle_to_act", 0, 0, 0, 0, 8'hFE, 8'h00);
        step("act_to_idle", 0, 0, 0, 0, 8'hFF, 8'h00);
        step("idle_to_act2", 0, 0, 0, 0, 8'h7F, 8'h00);
        step("act_hold", 0, 0, 0, 0, 8'h00, 8'h00);

        // Error beats init; ERROR absorbs everything but reset
        step("err_wins", 0, 1, 0, 0, 8'hFE, 8'h20);
        step("err_hold_init", 0, 1, 5, 1, 8'h00, 8'h00);
        step("err_hold_err", 0, 0, 5, 1, 8'hFF, 8'h0F);
        step("err_hold_empty", 0, 0, 5, 1, 8'hFF, 8'h00);

        // Reset out of ERROR, then reprogram
        step("err_reset", 1, 1, 5, 1, 8'hFF, 8'h01);
        step("post_reset_init", 0, 0, 5, 1, 8'hFF, 8'h00);
        step("prog_idle", 0, 0, 5, 1, 8'hFF, 8'h00);
        step("go_act", 0, 0, 5, 1, 8'hFE, 8'h00);
        step("act_to_init", 0, 1, 7, 4, 8'hFE, 8'h00);
        step("init_load", 0, 0, 7, 4, 8'hFF, 8'h00);
        step("thresh_hold", 0, 0, 2, 0, 8'hFF, 8'h00);
        step("thresh_hold2", 0, 1, 1, 0, 8'hFF, 8'h00);
        step("init_ignores_err", 0, 1, 4, 2, 8'hFF, 8'hFF);
        step("init_release", 0, 0, 4, 2, 8'hFF, 8'h00);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            r   = (m_st == 4) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            i   = ($urandom_range(0, 7) == 0);
            af  = TW'($urandom);
            ae  = TW'($urandom);
            emp = ($urandom_range(0, 1) == 0) ? {NF{1'b1}} : NF'($urandom);
            er  = ($urandom_range(0, 29) == 0) ? NF'(1 << $urandom_range(0, NF - 1)) : '0;
            step("random", r, i, af, ae, emp, er);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
